// File: rtl/spi_frame_loader.sv
// Command parser between the SPI byte slave and the LED channel memory.
// Decodes WRITE / COMMIT / STATUS transactions framed by chip select.
module spi_frame_loader #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int MEM_DEPTH     = 432
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               spi_dout,
  input  logic                     spi_done,
  input  logic                     spi_selected,
  output logic [7:0]               spi_din,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_din,
  output logic                     frame_commit,
  output logic                     status_overflow,
  output logic                     status_bad_cmd
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CMD         = 3'd1,
    ADDR_HI     = 3'd2,
    ADDR_LO     = 3'd3,
    DATA        = 3'd4,
    COMMIT_PEND = 3'd5,
    DISCARD     = 3'd6
  } state_t;

  localparam logic [15:0] MEM_LIMIT = 16'(MEM_DEPTH);

  state_t                     state_r, state_s;
  logic [7:0]                 addr_hi_r, addr_hi_s;
  logic [15:0]                work_addr_r, work_addr_s;
  logic [3:0]                 commit_count_r, commit_count_s;
  logic                       status_txn_r, status_txn_s;
  logic [7:0]                 spi_din_s;
  logic                       mem_we_s;
  logic [ADDRESS_WIDTH-1:0]   mem_addr_s;
  logic [7:0]                 mem_din_s;
  logic                       frame_commit_s;
  logic                       ovf_set_s, bad_set_s, flag_clr_s;
  logic                       status_overflow_s, status_bad_cmd_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode, byte processing and transaction-end handling
  always_comb begin
    state_s        = state_r;
    addr_hi_s      = addr_hi_r;
    work_addr_s    = work_addr_r;
    commit_count_s = commit_count_r;
    status_txn_s   = status_txn_r;
    spi_din_s      = spi_din;
    mem_we_s       = 1'b0;
    mem_addr_s     = mem_addr;
    mem_din_s      = mem_din;
    frame_commit_s = 1'b0;
    ovf_set_s      = 1'b0;
    bad_set_s      = 1'b0;
    flag_clr_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (spi_selected) begin
          state_s = CMD;
        end else begin
          state_s = IDLE;
        end
      end
      CMD: begin
        if (spi_done) begin
          case (spi_dout)
            8'h01: state_s = ADDR_HI;
            8'h02: state_s = COMMIT_PEND;
            8'h03: begin
              state_s      = DISCARD;
              status_txn_s = 1'b1;
              spi_din_s    = {status_overflow, status_bad_cmd, 2'b00, commit_count_r};
            end
            default: begin
              state_s   = DISCARD;
              bad_set_s = 1'b1;
            end
          endcase
        end else begin
          state_s = CMD;
        end
      end
      ADDR_HI: begin
        if (spi_done) begin
          addr_hi_s = spi_dout;
          state_s   = ADDR_LO;
        end else begin
          state_s = ADDR_HI;
        end
      end
      ADDR_LO: begin
        if (spi_done) begin
          work_addr_s = {addr_hi_r, spi_dout};
          state_s     = DATA;
        end else begin
          state_s = ADDR_LO;
        end
      end
      DATA: begin
        if (spi_done) begin
          if (work_addr_r < MEM_LIMIT) begin
            mem_we_s   = 1'b1;
            mem_addr_s = work_addr_r[ADDRESS_WIDTH-1:0];
            mem_din_s  = spi_dout;
          end else begin
            ovf_set_s = 1'b1;
          end
          // Saturate rather than wrap so overruns never alias to low addresses
          if (work_addr_r != 16'hFFFF) begin
            work_addr_s = work_addr_r + 16'd1;
          end else begin
            work_addr_s = work_addr_r;
          end
        end else begin
          state_s = DATA;
        end
      end
      COMMIT_PEND: state_s = COMMIT_PEND;
      DISCARD:     state_s = DISCARD;
      default:     state_s = IDLE;
    endcase

    // Deselect ends the transaction after any coincident byte is processed
    if ((state_r != IDLE) && !spi_selected) begin
      if (state_s == COMMIT_PEND) begin
        frame_commit_s = 1'b1;
        commit_count_s = commit_count_r + 4'd1;
      end else begin
        frame_commit_s = 1'b0;
      end
      flag_clr_s   = status_txn_s;
      status_txn_s = 1'b0;
      spi_din_s    = 8'h00;
      state_s      = IDLE;
    end else begin
      flag_clr_s = 1'b0;
    end

    status_overflow_s = (status_overflow & ~flag_clr_s) | ovf_set_s;
    status_bad_cmd_s  = (status_bad_cmd & ~flag_clr_s) | bad_set_s;
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hi_r       <= 8'h00;
      work_addr_r     <= 16'h0000;
      commit_count_r  <= 4'd0;
      status_txn_r    <= 1'b0;
      spi_din         <= 8'h00;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_din         <= 8'h00;
      frame_commit    <= 1'b0;
      status_overflow <= 1'b0;
      status_bad_cmd  <= 1'b0;
    end else begin
      addr_hi_r       <= addr_hi_s;
      work_addr_r     <= work_addr_s;
      commit_count_r  <= commit_count_s;
      status_txn_r    <= status_txn_s;
      spi_din         <= spi_din_s;
      mem_we          <= mem_we_s;
      mem_addr        <= mem_addr_s;
      mem_din         <= mem_din_s;
      frame_commit    <= frame_commit_s;
      status_overflow <= status_overflow_s;
      status_bad_cmd  <= status_bad_cmd_s;
    end
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboard bench for spi_frame_loader: stimulus pushes expected writes and
// commits with their cycle; a negedge monitor pops and compares.
module tb_spi_frame_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] spi_dout = 8'h00;
  logic       spi_done = 1'b0;
  logic       spi_selected = 1'b0;
  logic [7:0] spi_din;
  logic       mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_din;
  logic       frame_commit;
  logic       status_overflow;
  logic       status_bad_cmd;

  typedef struct {
    logic       is_commit;
    logic [8:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_we = 1'b0;

  spi_frame_loader #(.ADDRESS_WIDTH(9), .MEM_DEPTH(432)) dut (
    .clk(clk), .rst(rst), .spi_dout(spi_dout), .spi_done(spi_done),
    .spi_selected(spi_selected), .spi_din(spi_din), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .frame_commit(frame_commit),
    .status_overflow(status_overflow), .status_bad_cmd(status_bad_cmd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe or commit pulse must match the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        checks++;
        if (prev_we) begin
          errors++;
          $display("FAIL we_back_to_back at cycle %0d", cyc);
        end
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr %0d data %h at cycle %0d, expected nothing", mem_addr, mem_din, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.is_commit || e.addr != mem_addr || e.data != mem_din || e.cyc != cyc) begin
            errors++;
            $display("FAIL write got addr %0d data %h cyc %0d, expected commit=%0d addr %0d data %h cyc %0d",
                     mem_addr, mem_din, cyc, e.is_commit, e.addr, e.data, e.cyc);
          end
        end
      end
      if (frame_commit) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_commit at cycle %0d, expected nothing", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (!e.is_commit || e.cyc != cyc) begin
            errors++;
            $display("FAIL commit got commit at cyc %0d, expected commit=%0d cyc %0d", cyc, e.is_commit, e.cyc);
          end
        end
      end
    end
    prev_we = mem_we;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sel();
    @(posedge clk); #1;
    spi_selected = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic desel(input bit commit);
    @(posedge clk); #1;
    spi_selected = 1'b0;
    if (commit) q.push_back('{1'b1, 9'd0, 8'h00, cyc + 1});
    repeat (3) @(posedge clk);
  endtask

  // One byte; optionally expects a write and/or drops select on the same cycle
  task automatic send(input logic [7:0] b, input bit wr, input logic [8:0] a, input bit drop);
    @(posedge clk); #1;
    spi_dout = b;
    spi_done = 1'b1;
    if (drop) spi_selected = 1'b0;
    if (wr) q.push_back('{1'b0, a, b, cyc + 1});
    @(posedge clk); #1;
    spi_done = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_spi_din", {8'h00, spi_din}, 16'h0000);
    chk("rst_mem_we", {15'd0, mem_we}, 16'h0000);
    chk("rst_mem_addr", {7'd0, mem_addr}, 16'h0000);
    chk("rst_mem_din", {8'h00, mem_din}, 16'h0000);
    chk("rst_frame_commit", {15'd0, frame_commit}, 16'h0000);
    chk("rst_overflow", {15'd0, status_overflow}, 16'h0000);
    chk("rst_bad_cmd", {15'd0, status_bad_cmd}, 16'h0000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;

    // Plain write burst at 5..7
    sel();
    send(8'h01, 0, 9'd0, 0); send(8'h00, 0, 9'd0, 0); send(8'h05, 0, 9'd0, 0);
    send(8'hAA, 1, 9'd5, 0); send(8'hBB, 1, 9'd6, 0); send(8'hCC, 1, 9'd7, 0);
    desel(0);

    // Overflow: start 430, third byte dropped
    sel();
    send(8'h01, 0, 9'd0, 0); send(8'h01, 0, 9'd0, 0); send(8'hAE, 0, 9'd0, 0);
    send(8'h11, 1, 9'd430, 0); send(8'h22, 1, 9'd431, 0); send(8'h33, 0, 9'd0, 0);
    desel(0);
    chk("overflow_set", {15'd0, status_overflow}, 16'h0001);
    chk("bad_cmd_clear", {15'd0, status_bad_cmd}, 16'h0000);

    // Status read reports overflow, count 0, then clears flags
    sel();
    send(8'h03, 0, 9'd0, 0);
    chk("status_ovf", {8'h00, spi_din}, 16'h0080);
    desel(0);
    chk("status_cleared_ovf", {15'd0, status_overflow}, 16'h0000);
    chk("spi_din_idle", {8'h00, spi_din}, 16'h0000);

    // Three commits, the last with a trailing ignored byte
    sel(); send(8'h02, 0, 9'd0, 0); desel(1);
    sel(); send(8'h02, 0, 9'd0, 0); desel(1);
    sel(); send(8'h02, 0, 9'd0, 0); send(8'hFF, 0, 9'd0, 0); desel(1);

    // Unknown opcode then status read
    sel(); send(8'h7E, 0, 9'd0, 0); send(8'h01, 0, 9'd0, 0); desel(0);
    chk("bad_cmd_set", {15'd0, status_bad_cmd}, 16'h0001);
    sel();
    send(8'h03, 0, 9'd0, 0);
    chk("status_bad_cnt3", {8'h00, spi_din}, 16'h0043);
    desel(0);
    chk("status_cleared_bad", {15'd0, status_bad_cmd}, 16'h0000);
    chk("status_cleared_ovf2", {15'd0, status_overflow}, 16'h0000);

    // Early deselect: no write, no flag; then write with coincident deselect
    sel(); send(8'h01, 0, 9'd0, 0); send(8'h00, 0, 9'd0, 0); desel(0);
    chk("early_desel_ovf", {15'd0, status_overflow}, 16'h0000);
    chk("early_desel_bad", {15'd0, status_bad_cmd}, 16'h0000);
    sel();
    send(8'h01, 0, 9'd0, 0); send(8'h00, 0, 9'd0, 0); send(8'h00, 0, 9'd0, 0);
    send(8'h12, 1, 9'd0, 1);
    chk("coincident_addr", {7'd0, mem_addr}, 16'h0000);
    chk("coincident_data", {8'h00, mem_din}, 16'h0012);

    // Reset mid-DATA; select stays high so following bytes form a bad command
    sel();
    send(8'h01, 0, 9'd0, 0); send(8'h00, 0, 9'd0, 0); send(8'h10, 0, 9'd0, 0);
    send(8'hA5, 1, 9'd16, 0); send(8'h5A, 1, 9'd17, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals();
    rst = 1'b0;
    send(8'h44, 0, 9'd0, 0); send(8'h55, 0, 9'd0, 0);
    desel(0);
    chk("post_rst_bad", {15'd0, status_bad_cmd}, 16'h0001);
    chk("post_rst_ovf", {15'd0, status_overflow}, 16'h0000);
    sel();
    send(8'h03, 0, 9'd0, 0);
    chk("post_rst_status", {8'h00, spi_din}, 16'h0040);
    desel(0);
    chk("post_rst_cleared", {15'd0, status_bad_cmd}, 16'h0000);

    repeat (5) @(posedge clk);
    chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
Command parser between the SPI byte slave and the shared LED channel memory. It decodes per-chip-select transactions (write, commit, status). Write transactions stream bytes into memory with auto-incrementing addresses. A commit tells the strip drivers that a complete frame is loaded.

Parameters:
ADDRESS_WIDTH, 9, width of mem_addr
MEM_DEPTH, 432, number of valid byte locations (NUM_CHANNELS*NUM_DRIVERS); writes at or above this are dropped

Ports:
clk  input  1  system clock (50 MHz domain)
rst  input  1  synchronous, active-high reset
spi_dout  input  8  byte received from SPI slave, valid when spi_done=1
spi_done  input  1  one-cycle pulse per received byte
spi_selected  input  1  high while chip select asserted
spi_din  output  8  byte to shift out on the next SPI byte
mem_we  output  1  one-cycle write strobe; memory samples on its rising edge
mem_addr  output  ADDRESS_WIDTH  write address, stable while mem_we high
mem_din  output  8  write data, stable while mem_we high
frame_commit  output  1  one-cycle pulse: frame complete
status_overflow  output  1  sticky: write attempted at address >= MEM_DEPTH
status_bad_cmd  output  1  sticky: unknown opcode received

Behaviour:
- Single clock clk. Reset synchronous, active-high on rst. Reset mid-transaction aborts it: no further mem_we, no pending commit.
- Reset values: state IDLE, spi_din=8'h00, mem_we=0, mem_addr=0, mem_din=0, frame_commit=0, both status flags 0, commit counter 0.
- Opcodes (first byte of a transaction): 8'h01 WRITE, 8'h02 COMMIT, 8'h03 STATUS. Any other value is unknown.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, DATA, COMMIT_PEND, DISCARD.
- IDLE -> CMD when spi_selected=1.
- CMD on spi_done:
  - 01 -> ADDR_HI.
  - 02 -> COMMIT_PEND.
  - 03 -> DISCARD, and load spi_din with the status byte.
  - other -> DISCARD, and set status_bad_cmd.
- ADDR_HI on spi_done -> ADDR_LO. The byte is latched as the upper 8 bits of a 16-bit start address.
- ADDR_LO on spi_done -> DATA, with working address = {hi,lo}. Use the 16-bit value for the range check; mem_addr uses the low ADDRESS_WIDTH bits.
- DATA on spi_done:
  - If working address < MEM_DEPTH: on the next cycle, mem_addr = working address, mem_din = spi_dout, mem_we = 1 for exactly one cycle. mem_addr and mem_din are registered and hold until the next write.
  - Otherwise: no strobe, and set status_overflow.
  - Working address increments every data byte, saturating at 16'hFFFF. There is no wrap.
- COMMIT_PEND: extra bytes are ignored.
- DISCARD: bytes are ignored.
- Deselect (spi_selected=0) in any non-IDLE state -> IDLE on the next clock.
  - If leaving COMMIT_PEND: frame_commit pulses 1 cycle and the 4-bit commit counter increments (wraps 15->0).
  - If leaving via a STATUS transaction: clear both sticky flags after the transaction ends. A flag set in the same cycle still wins (set has priority).
  - Deselect before ADDR_LO completes: no writes, no error.
- spi_done coincident with deselect: the byte is processed normally first (a data byte still writes), then IDLE.
- spi_done while in IDLE is ignored.
- Status byte = {status_overflow, status_bad_cmd, 2'b00, commit_count[3:0]}, captured at the opcode byte.
- spi_din returns to 8'h00 on entering IDLE.
- Latency: data byte spi_done at cycle N -> mem_we high at N+1. Commit deselect seen at cycle N -> frame_commit at N+1.
- mem_we is never high for two consecutive cycles. spi_done spacing is >=8 SPI clocks, so no buffering is needed.

Test Plan:
- Select; send 01,00,05,AA,BB,CC; deselect -> three mem_we pulses at addr 5/6/7 with data AA/BB/CC, each one cycle after its spi_done. No frame_commit.
- Send 01,01,AE,11,22,33 (start 430, MEM_DEPTH=432) -> writes at 430,431 only; status_overflow=1; no write at address 0.
- Send 02; deselect -> exactly one frame_commit pulse one cycle after deselect. Second commit transaction -> count=2. Send 02,FF; deselect -> commit still pulses.
- Send 7E then 03 in a new transaction -> status_bad_cmd=1; status byte on spi_din = 8'h40 | count. After the 03 transaction ends, both flags read 0.
- Send 01,00; deselect -> no mem_we, no flags. Send 01,00,00,12 with spi_done coincident with the deselect -> write of 12 at addr 0.
- Assert rst during the DATA state after 2 bytes -> all outputs take reset values; subsequent bytes produce no mem_we until a new transaction starts.
